// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sequencing CPU/aux accesses onto the one-cycle chip-select memory port.
// Write ack lands 2 cycles after the sampling edge, read ack 2+RD_LAT; requesters hold req until ack.
module mem_bus_arbiter #(
   parameter int AW         = 7,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,
   parameter int FIXED_PRIO = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic [DW-1:0] aux_rdata,
   output logic          aux_ack,
   output logic          CS,
   output logic          WE,
   output logic [AW-1:0] Address,
   inout  wire  [DW-1:0] Mem_Bus
);

   localparam int CNT_W = 2;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_rr;
   logic              r_own;
   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cs;
   logic              r_wen;
   logic              r_cpu_ack;
   logic              r_aux_ack;
   logic [DW-1:0]     r_cpu_rdata;
   logic [DW-1:0]     r_aux_rdata;
   logic              w_grant;
   logic              w_pick_aux;
   logic              w_sel_we;
   logic              w_last;

   assign w_last   = r_we || (r_cnt == CNT_W'(RD_LAT));
   assign w_sel_we = w_pick_aux ? aux_we : cpu_we;

   always_comb begin
      w_next     = r_state;
      w_grant    = 1'b0;
      w_pick_aux = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cpu_req || aux_req) begin
               w_next  = S_ACC;
               w_grant = 1'b1;
               if (cpu_req && aux_req) w_pick_aux = (FIXED_PRIO == 0) ? r_rr : 1'b0;
               else                    w_pick_aux = aux_req;
            end
         end
         S_ACC:   if (w_last) w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_rr        <= 1'b0;
         r_own       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_cs        <= 1'b0;
         r_wen       <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_aux_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_aux_rdata <= '0;
      end else begin
         r_state   <= w_next;
         r_cs      <= (w_next == S_ACC);
         r_wen     <= (w_next == S_ACC) && (w_grant ? w_sel_we : r_we);
         r_cpu_ack <= (r_state == S_ACC) && w_last && !r_own;
         r_aux_ack <= (r_state == S_ACC) && w_last &&  r_own;
         if (w_grant) begin
            r_own   <= w_pick_aux;
            r_we    <= w_sel_we;
            r_addr  <= w_pick_aux ? aux_addr  : cpu_addr;
            r_wdata <= w_pick_aux ? aux_wdata : cpu_wdata;
            r_cnt   <= '0;
            // pointer only moves when there was a real contest
            if (cpu_req && aux_req && FIXED_PRIO == 0) r_rr <= ~w_pick_aux;
         end else if (r_state == S_ACC) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == S_ACC && w_last && !r_we) begin
            if (r_own) r_aux_rdata <= Mem_Bus;
            else       r_cpu_rdata <= Mem_Bus;
         end
      end
   end

   assign CS        = r_cs;
   assign WE        = r_wen;
   assign Address   = r_addr;
   assign cpu_ack   = r_cpu_ack;
   assign aux_ack   = r_aux_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign aux_rdata = r_aux_rdata;
   // bus is only ever driven while a write is on the port, never during a read
   assign Mem_Bus   = (r_cs && r_wen) ? r_wdata : {DW{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: round-robin/RD_LAT=1 instance A and fixed-priority/RD_LAT=2 instance B,
// each with a small memory model on its Mem_Bus; expected acks are queued and popped on ack.
module tb_mem_bus_arbiter;

   typedef struct {
      bit          aux;
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic        a_cpu_req, a_cpu_we, a_aux_req, a_aux_we;
   logic [6:0]  a_cpu_addr, a_aux_addr;
   logic [31:0] a_cpu_wdata, a_aux_wdata;
   logic [31:0] a_cpu_rdata, a_aux_rdata;
   logic        a_cpu_ack, a_aux_ack, a_CS, a_WE;
   logic [6:0]  a_Address;
   wire  [31:0] a_bus;

   logic        b_cpu_req, b_cpu_we, b_aux_req, b_aux_we;
   logic [6:0]  b_cpu_addr, b_aux_addr;
   logic [31:0] b_cpu_wdata, b_aux_wdata;
   logic [31:0] b_cpu_rdata, b_aux_rdata;
   logic        b_cpu_ack, b_aux_ack, b_CS, b_WE;
   logic [6:0]  b_Address;
   wire  [31:0] b_bus;

   mem_bus_arbiter #(.AW(7), .DW(32), .RD_LAT(1), .FIXED_PRIO(0)) u_a (
      .CLK(CLK), .RST(RST),
      .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
      .aux_req(a_aux_req), .aux_we(a_aux_we), .aux_addr(a_aux_addr), .aux_wdata(a_aux_wdata),
      .aux_rdata(a_aux_rdata), .aux_ack(a_aux_ack),
      .CS(a_CS), .WE(a_WE), .Address(a_Address), .Mem_Bus(a_bus));

   mem_bus_arbiter #(.AW(7), .DW(32), .RD_LAT(2), .FIXED_PRIO(1)) u_b (
      .CLK(CLK), .RST(RST),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
      .aux_req(b_aux_req), .aux_we(b_aux_we), .aux_addr(b_aux_addr), .aux_wdata(b_aux_wdata),
      .aux_rdata(b_aux_rdata), .aux_ack(b_aux_ack),
      .CS(b_CS), .WE(b_WE), .Address(b_Address), .Mem_Bus(b_bus));

   // Memory models: unwritten words read back as C0DE0000 | addr
   logic [31:0] memA [128];
   bit   [127:0] wrA;
   logic        mA_drv;
   logic [31:0] mA_q;
   always @(posedge CLK or posedge RST) begin
      if (RST) mA_drv <= 1'b0;
      else begin
         mA_drv <= a_CS && !a_WE;
         mA_q   <= wrA[a_Address] ? memA[a_Address] : (32'hC0DE0000 | {25'h0, a_Address});
         if (a_CS && a_WE) begin
            memA[a_Address] <= a_bus;
            wrA[a_Address]  <= 1'b1;
         end
      end
   end
   assign a_bus = mA_drv ? mA_q : 32'hzzzzzzzz;

   logic [31:0] memB [128];
   bit   [127:0] wrB;
   logic        mB_drv;
   logic [31:0] mB_q;
   always @(posedge CLK or posedge RST) begin
      if (RST) mB_drv <= 1'b0;
      else begin
         mB_drv <= b_CS && !b_WE;
         mB_q   <= wrB[b_Address] ? memB[b_Address] : (32'hC0DE0000 | {25'h0, b_Address});
         if (b_CS && b_WE) begin
            memB[b_Address] <= b_bus;
            wrB[b_Address]  <= 1'b1;
         end
      end
   end
   assign b_bus = mB_drv ? mB_q : 32'hzzzzzzzz;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb[$];
   exp_t        e;
   logic [31:0] m_crd_a = '0, m_ard_a = '0, m_crd_b = '0, m_ard_b = '0;

   int          lat, csn, wen, drv;
   bit          to, ga, both;
   logic [31:0] crd, ard;
   logic [6:0]  adr;

   function automatic bit is_float(input logic [31:0] v);
      return (v === 32'hzzzzzzzz) || (v === 32'h0);
   endfunction

   // Observe one access from the sampling edge to its ack, with a cycle budget
   task automatic wait_ack(input bit inst);
      bit done;
      logic cs, we, ca, aa, md;
      logic [31:0] bus;
      done = 0; lat = 0; to = 0; ga = 0; both = 0; csn = 0; wen = 0; drv = 0;
      adr = '0; crd = '0; ard = '0;
      for (int c = 1; c <= 24 && !done; c++) begin
         @(negedge CLK);
         cs  = inst ? b_CS : a_CS;
         we  = inst ? b_WE : a_WE;
         ca  = inst ? b_cpu_ack : a_cpu_ack;
         aa  = inst ? b_aux_ack : a_aux_ack;
         md  = inst ? mB_drv : mA_drv;
         bus = inst ? b_bus : a_bus;
         if (cs) begin csn++; adr = inst ? b_Address : a_Address; end
         if (we) wen++;
         if (!md && !is_float(bus)) drv++;
         if (ca || aa) begin
            done = 1; lat = c; ga = aa; both = ca && aa;
            crd = inst ? b_cpu_rdata : a_cpu_rdata;
            ard = inst ? b_aux_rdata : a_aux_rdata;
         end
      end
      if (!done) to = 1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #2 RST = 1'b1;
      #2;
      n_cmp++; if ({a_CS, a_WE, a_cpu_ack, a_aux_ack} !== 4'b0) begin n_bad++;
         $display("FAIL rst_ctl: got cs/we/acks %b need 0000", {a_CS, a_WE, a_cpu_ack, a_aux_ack}); end
      n_cmp++; if (a_Address !== 7'd0) begin n_bad++;
         $display("FAIL rst_addr: got %0d need 0", a_Address); end
      n_cmp++; if (a_cpu_rdata !== 32'h0 || a_aux_rdata !== 32'h0) begin n_bad++;
         $display("FAIL rst_rdata: got %h/%h need 0/0", a_cpu_rdata, a_aux_rdata); end
      n_cmp++; if (!is_float(a_bus)) begin n_bad++;
         $display("FAIL rst_bus: got %h need Z", a_bus); end
      @(negedge CLK); @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_cpu_write();
      a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 7'd23; a_cpu_wdata = 32'hDEADBEEF;
      sb.push_back('{aux: 1'b0, data: 32'h0, lat: 2});
      wait_ack(1'b0);
      a_cpu_req = 0;
      e = sb.pop_front();
      n_cmp++; if (to || ga !== e.aux || both) begin n_bad++;
         $display("FAIL wr_owner: got timeout=%0d aux=%0d both=%0d need cpu ack", to, ga, both); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL wr_lat: got %0d need %0d", lat, e.lat); end
      n_cmp++; if (csn !== 1 || wen !== 1 || adr !== 7'd23) begin n_bad++;
         $display("FAIL wr_port: got cs=%0d we=%0d addr=%0d need 1/1/23", csn, wen, adr); end
      n_cmp++; if (drv !== 1) begin n_bad++; $display("FAIL wr_drive: got %0d cycles need 1", drv); end
      n_cmp++; if (memA[23] !== 32'hDEADBEEF) begin n_bad++;
         $display("FAIL wr_mem: got %h need DEADBEEF", memA[23]); end
      @(negedge CLK);
   endtask

   task automatic test_cpu_read();
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 7'd23; a_cpu_wdata = 32'hBAD0BAD0;
      sb.push_back('{aux: 1'b0, data: 32'hDEADBEEF, lat: 3});
      wait_ack(1'b0);
      a_cpu_req = 0;
      e = sb.pop_front();
      m_crd_a = e.data;
      n_cmp++; if (to || ga !== e.aux) begin n_bad++;
         $display("FAIL rd_owner: got timeout=%0d aux=%0d need cpu", to, ga); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rd_lat: got %0d need %0d", lat, e.lat); end
      n_cmp++; if (csn !== 2 || wen !== 0 || drv !== 0) begin n_bad++;
         $display("FAIL rd_port: got cs=%0d we=%0d drive=%0d need 2/0/0", csn, wen, drv); end
      n_cmp++; if (crd !== m_crd_a || ard !== m_ard_a) begin n_bad++;
         $display("FAIL rd_data: got %h/%h need %h/%h", crd, ard, m_crd_a, m_ard_a); end
      @(negedge CLK);
   endtask

   task automatic test_round_robin();
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 7'd5; a_cpu_wdata = 32'hBAD0BAD0;
      a_aux_req = 1; a_aux_we = 0; a_aux_addr = 7'd6; a_aux_wdata = 32'hBAD1BAD1;
      for (int i = 0; i < 4; i++)
         sb.push_back('{aux: (i % 2 == 1), data: (i % 2 == 1) ? 32'hC0DE0006 : 32'hC0DE0005, lat: -1});
      for (int i = 0; i < 4; i++) begin
         wait_ack(1'b0);
         if (i == 3) begin a_cpu_req = 0; a_aux_req = 0; end
         e = sb.pop_front();
         if (e.aux) m_ard_a = e.data; else m_crd_a = e.data;
         n_cmp++; if (to || ga !== e.aux || both) begin n_bad++;
            $display("FAIL rr_grant%0d: got timeout=%0d aux=%0d both=%0d need aux=%0d", i, to, ga, both, e.aux); end
         n_cmp++; if (crd !== m_crd_a || ard !== m_ard_a) begin n_bad++;
            $display("FAIL rr_data%0d: got %h/%h need %h/%h", i, crd, ard, m_crd_a, m_ard_a); end
      end
      @(negedge CLK);
   endtask

   task automatic test_fixed_prio();
      b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 7'd5; b_cpu_wdata = 32'hBAD0BAD0;
      b_aux_req = 1; b_aux_we = 0; b_aux_addr = 7'd6; b_aux_wdata = 32'hBAD1BAD1;
      sb.push_back('{aux: 1'b0, data: 32'hC0DE0005, lat: 4});
      sb.push_back('{aux: 1'b0, data: 32'hC0DE0005, lat: -1});
      sb.push_back('{aux: 1'b0, data: 32'hC0DE0005, lat: -1});
      sb.push_back('{aux: 1'b1, data: 32'hC0DE0006, lat: -1});
      for (int i = 0; i < 4; i++) begin
         wait_ack(1'b1);
         if (i == 2) b_cpu_req = 0;
         if (i == 3) b_aux_req = 0;
         e = sb.pop_front();
         if (e.aux) m_ard_b = e.data; else m_crd_b = e.data;
         n_cmp++; if (to || ga !== e.aux || both) begin n_bad++;
            $display("FAIL fp_grant%0d: got timeout=%0d aux=%0d both=%0d need aux=%0d", i, to, ga, both, e.aux); end
         n_cmp++; if (crd !== m_crd_b || ard !== m_ard_b) begin n_bad++;
            $display("FAIL fp_data%0d: got %h/%h need %h/%h", i, crd, ard, m_crd_b, m_ard_b); end
         if (e.lat >= 0) begin
            n_cmp++; if (lat !== e.lat) begin n_bad++;
               $display("FAIL fp_lat: got %0d need %0d", lat, e.lat); end
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_aux_write_cpu_read();
      a_aux_req = 1; a_aux_we = 1; a_aux_addr = 7'd10; a_aux_wdata = 32'h12345678;
      sb.push_back('{aux: 1'b1, data: 32'h0, lat: 2});
      wait_ack(1'b0);
      a_aux_req = 0;
      e = sb.pop_front();
      n_cmp++; if (to || ga !== e.aux || lat !== e.lat) begin n_bad++;
         $display("FAIL aw_ack: got timeout=%0d aux=%0d lat=%0d need aux=1 lat=%0d", to, ga, lat, e.lat); end
      n_cmp++; if (drv !== 1 || memA[10] !== 32'h12345678) begin n_bad++;
         $display("FAIL aw_mem: got drive=%0d mem=%h need 1/12345678", drv, memA[10]); end
      n_cmp++; if (crd !== m_crd_a || ard !== m_ard_a) begin n_bad++;
         $display("FAIL aw_hold: got %h/%h need %h/%h", crd, ard, m_crd_a, m_ard_a); end
      @(negedge CLK);
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 7'd10; a_cpu_wdata = 32'hBAD0BAD0;
      sb.push_back('{aux: 1'b0, data: 32'h12345678, lat: 3});
      wait_ack(1'b0);
      a_cpu_req = 0;
      e = sb.pop_front();
      m_crd_a = e.data;
      n_cmp++; if (to || ga !== e.aux || lat !== e.lat || drv !== 0) begin n_bad++;
         $display("FAIL cr_ack: got timeout=%0d aux=%0d lat=%0d drive=%0d need cpu/%0d/0", to, ga, lat, drv, e.lat); end
      n_cmp++; if (crd !== m_crd_a || ard !== m_ard_a) begin n_bad++;
         $display("FAIL cr_data: got %h/%h need %h/%h", crd, ard, m_crd_a, m_ard_a); end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_read();
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 7'd23; a_cpu_wdata = 32'hBAD0BAD0;
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++; if (a_CS !== 1'b1 || a_WE !== 1'b0) begin n_bad++;
         $display("FAIL mid_acc: got cs=%b we=%b need 1/0", a_CS, a_WE); end
      #2 RST = 1'b1;
      #1;
      n_cmp++; if ({a_CS, a_WE, a_cpu_ack, a_aux_ack} !== 4'b0) begin n_bad++;
         $display("FAIL mid_ctl: got cs/we/acks %b need 0000", {a_CS, a_WE, a_cpu_ack, a_aux_ack}); end
      n_cmp++; if (a_cpu_rdata !== 32'h0 || a_aux_rdata !== 32'h0) begin n_bad++;
         $display("FAIL mid_rdata: got %h/%h need 0/0", a_cpu_rdata, a_aux_rdata); end
      n_cmp++; if (!is_float(a_bus)) begin n_bad++; $display("FAIL mid_bus: got %h need Z", a_bus); end
      m_crd_a = '0; m_ard_a = '0;
      a_cpu_req = 0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      a_aux_req = 1; a_aux_we = 0; a_aux_addr = 7'd23; a_aux_wdata = 32'hBAD1BAD1;
      sb.push_back('{aux: 1'b1, data: 32'hDEADBEEF, lat: 3});
      wait_ack(1'b0);
      a_aux_req = 0;
      e = sb.pop_front();
      m_ard_a = e.data;
      n_cmp++; if (to || ga !== e.aux || lat !== e.lat) begin n_bad++;
         $display("FAIL post_ack: got timeout=%0d aux=%0d lat=%0d need aux=1 lat=%0d", to, ga, lat, e.lat); end
      n_cmp++; if (crd !== m_crd_a || ard !== m_ard_a) begin n_bad++;
         $display("FAIL post_data: got %h/%h need %h/%h", crd, ard, m_crd_a, m_ard_a); end
      @(negedge CLK);
   endtask

   initial begin
      a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = '0; a_cpu_wdata = '0;
      a_aux_req = 0; a_aux_we = 0; a_aux_addr = '0; a_aux_wdata = '0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_aux_req = 0; b_aux_we = 0; b_aux_addr = '0; b_aux_wdata = '0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_round_robin();
      test_fixed_prio();
      test_aux_write_cpu_read();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
      $fatal(1);
   end

endmodule
